// File: rtl/accum_skid_pkg.sv
// Shared types and constants for the accumulator skid stage.
package accum_skid_pkg;

    localparam int          DATA_W     = 32;
    localparam logic [1:0]  SKID_DEPTH = 2'd2;

    typedef struct packed {
        logic [DATA_W-1:0] sum;
        logic [DATA_W-1:0] bypass_data;
    } result_t;

endpackage

// File: rtl/skid_fifo2.sv
// Generic 2-entry valid/ready skid buffer; the head register keeps its last
// value when the buffer drains so consumers see stable data while empty.
module skid_fifo2
    import accum_skid_pkg::*;
#(
    parameter type entry_t = result_t
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  entry_t     push_data,
    input  logic       pop,
    output entry_t     head_data,
    output logic [1:0] count
);

    entry_t     head_q, head_d;
    entry_t     tail_q, tail_d;
    logic [1:0] count_q, count_d;
    logic       pushOk;
    logic       popOk;

    assign popOk  = pop && (count_q != 2'd0);
    assign pushOk = push && ((count_q != SKID_DEPTH) || popOk);

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        unique case ({pushOk, popOk})
            2'b10: begin
                if (count_q == 2'd0) head_d = push_data;
                else                 tail_d = push_data;
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                if (count_q == SKID_DEPTH) head_d = tail_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                // Simultaneous push and pop keeps the count; a full buffer shifts.
                if (count_q == 2'd1) begin
                    head_d = push_data;
                end else begin
                    head_d = tail_q;
                    tail_d = push_data;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign head_data = head_q;
    assign count     = count_q;

endmodule

// File: rtl/accum_skid_stage.sv
// Streaming accumulator with optional bypass, feeding a 2-entry skid buffer.
// Define ACCUM_SKID_SAT_EN for a saturating add and the sat_flag output.
module accum_skid_stage
    import accum_skid_pkg::*;
#(
    parameter int               WIDTH = 32,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_bypass,
    input  logic             sum_clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic [WIDTH-1:0] out_bypass_data,
    output logic [1:0]       occupancy
`ifdef ACCUM_SKID_SAT_EN
    ,
    output logic             sat_flag
`endif
);

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic [WIDTH-1:0] bypass_data;
    } entry_t;

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] newAcc;
    logic             accept;
    logic             pop;
    entry_t           pushEntry;
    entry_t           headEntry;

    assign in_ready  = (occupancy != SKID_DEPTH);
    assign out_valid = (occupancy != 2'd0);
    assign accept    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign base      = sum_clear ? '0 : acc_q;

`ifdef ACCUM_SKID_SAT_EN
    logic [WIDTH:0] sumExt;
    logic           carry;
    logic           sat_q;

    assign sumExt = {1'b0, base} + {1'b0, in_data};
    assign carry  = sumExt[WIDTH];
    assign newAcc = carry ? '1 : sumExt[WIDTH-1:0];

    // A clear cannot coincide with a carry, since 0 + in_data never overflows.
    always_ff @(posedge clk) begin
        if (rst)                  sat_q <= 1'b0;
        else if (accept && carry) sat_q <= 1'b1;
        else if (sum_clear)       sat_q <= 1'b0;
    end

    assign sat_flag = sat_q;
`else
    assign newAcc = base + in_data;
`endif

    always_comb begin
        acc_d = acc_q;
        if (accept)         acc_d = newAcc;
        else if (sum_clear) acc_d = INIT;
    end

    always_ff @(posedge clk) begin
        if (rst) acc_q <= INIT;
        else     acc_q <= acc_d;
    end

    assign pushEntry.sum         = newAcc;
    assign pushEntry.bypass_data = in_bypass ? in_data : newAcc;

    skid_fifo2 #(
        .entry_t (entry_t)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (accept),
        .push_data (pushEntry),
        .pop       (pop),
        .head_data (headEntry),
        .count     (occupancy)
    );

    assign out_sum         = headEntry.sum;
    assign out_bypass_data = headEntry.bypass_data;

endmodule

// File: tb/tb_accum_skid_stage.sv
// Scoreboard bench for accum_skid_stage at WIDTH=8, INIT=0; follows
// ACCUM_SKID_SAT_EN when it is defined.
module tb_accum_skid_stage;

    localparam int         W    = 8;
    localparam logic [7:0] INIT = 8'd0;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         in_bypass;
    logic         sum_clear;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic [W-1:0] out_bypass_data;
    logic [1:0]   occupancy;
`ifdef ACCUM_SKID_SAT_EN
    logic         sat_flag;
`endif

    typedef struct {
        logic [W-1:0] sum;
        logic [W-1:0] byp;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;
    int   maxOcc = 0;

    accum_skid_stage #(
        .WIDTH (W),
        .INIT  (INIT)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_data         (in_data),
        .in_bypass       (in_bypass),
        .sum_clear       (sum_clear),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_sum         (out_sum),
        .out_bypass_data (out_bypass_data),
        .occupancy       (occupancy)
`ifdef ACCUM_SKID_SAT_EN
        ,
        .sat_flag        (sat_flag)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, expected);
        end
    endtask

    // Offer one sample; the expected result is queued when the accept is certain.
    task automatic applyStimulus(input logic [W-1:0] data, input logic byp, input logic clr,
                                 input logic [W-1:0] expSum, input logic [W-1:0] expByp);
        bit accepted = 0;
        exp_t e;
        in_valid  = 1'b1;
        in_data   = data;
        in_bypass = byp;
        sum_clear = clr;
        for (int i = 0; i < 50 && !accepted; i++) begin
            @(negedge clk);
            if (in_ready) begin
                e.sum = expSum;
                e.byp = expByp;
                expQ.push_back(e);
                accepted = 1;
            end
            @(posedge clk);
            #1;
        end
        if (!accepted) checkOutput("accept_timeout", 32'd0, 32'd1);
        in_valid  = 1'b0;
        in_bypass = 1'b0;
        sum_clear = 1'b0;
    endtask

    task automatic waitDrain();
        int n = 0;
        while ((expQ.size() != 0 || occupancy != 2'd0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain", 32'(expQ.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (32'(occupancy) > maxOcc) maxOcc = 32'(occupancy);
        if (!rst && out_valid && out_ready) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_output", 32'(out_sum), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                checkOutput("out_sum", 32'(out_sum), 32'(e.sum));
                checkOutput("out_bypass_data", 32'(out_bypass_data), 32'(e.byp));
            end
        end
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_bypass = 1'b0;
        sum_clear = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_occupancy", 32'(occupancy), 32'd0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_out_sum", 32'(out_sum), 32'd0);
        checkOutput("rst_out_bypass", 32'(out_bypass_data), 32'd0);
        @(posedge clk);
        #1;

        out_ready = 1'b1;
        maxOcc = 0;
        applyStimulus(8'd0,  1'b0, 1'b0, 8'd0,  8'd0);
        applyStimulus(8'd5,  1'b0, 1'b0, 8'd5,  8'd5);
        applyStimulus(8'd10, 1'b0, 1'b0, 8'd15, 8'd15);
        applyStimulus(8'd15, 1'b0, 1'b0, 8'd30, 8'd30);
        waitDrain();
        checkOutput("stream_max_occupancy", 32'(maxOcc), 32'd1);
        checkOutput("empty_hold_sum", 32'(out_sum), 32'd30);

        applyStimulus(8'd20, 1'b1, 1'b0, 8'd50, 8'd20);
        waitDrain();

        out_ready = 1'b0;
        applyStimulus(8'd1, 1'b0, 1'b1, 8'd1, 8'd1);
        applyStimulus(8'd2, 1'b0, 1'b0, 8'd3, 8'd3);
        @(negedge clk);
        checkOutput("stall_occupancy", 32'(occupancy), 32'd2);
        checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
        checkOutput("stall_out_valid", 32'(out_valid), 32'd1);
        checkOutput("stall_head", 32'(out_sum), 32'd1);
        @(posedge clk);
        #1;
        fork
            applyStimulus(8'd3, 1'b0, 1'b0, 8'd6, 8'd6);
            begin
                repeat (3) @(negedge clk);
                checkOutput("stall_hold_occ", 32'(occupancy), 32'd2);
                checkOutput("stall_hold_head", 32'(out_sum), 32'd1);
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        waitDrain();

`ifdef ACCUM_SKID_SAT_EN
        applyStimulus(8'd250, 1'b0, 1'b1, 8'd250, 8'd250);
        applyStimulus(8'd10,  1'b0, 1'b0, 8'd255, 8'd255);
        waitDrain();
        checkOutput("sat_flag_set", 32'(sat_flag), 32'd1);
`else
        applyStimulus(8'd250, 1'b0, 1'b1, 8'd250, 8'd250);
        applyStimulus(8'd10,  1'b0, 1'b0, 8'd4,   8'd4);
        waitDrain();
`endif

        applyStimulus(8'd100, 1'b0, 1'b1, 8'd100, 8'd100);
        applyStimulus(8'd7,   1'b0, 1'b1, 8'd7,   8'd7);
        sum_clear = 1'b1;
        @(posedge clk);
        #1 sum_clear = 1'b0;
        applyStimulus(8'd3, 1'b0, 1'b0, INIT + 8'd3, INIT + 8'd3);
        waitDrain();
`ifdef ACCUM_SKID_SAT_EN
        checkOutput("sat_flag_cleared", 32'(sat_flag), 32'd0);
`endif

        out_ready = 1'b0;
        applyStimulus(8'd4, 1'b0, 1'b0, 8'd7,  8'd7);
        applyStimulus(8'd5, 1'b0, 1'b0, 8'd12, 8'd12);
        @(negedge clk);
        checkOutput("prereset_occupancy", 32'(occupancy), 32'd2);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        expQ.delete();
        @(negedge clk);
        checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("midrst_occupancy", 32'(occupancy), 32'd0);
        checkOutput("midrst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("midrst_out_sum", 32'(out_sum), 32'd0);
        @(posedge clk);
        #1 out_ready = 1'b1;
        applyStimulus(8'd9, 1'b0, 1'b0, INIT + 8'd9, INIT + 8'd9);
        waitDrain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/accum_skid_stage.md
Name: accum_skid_stage

Overview:
- Streaming accumulator stage with optional bypass, fed by the stimulus/driver stage.
- Consumes a valid/ready stream of WIDTH-bit samples and keeps a running sum.
- Each accepted sample produces one result pair {sum, bypass-selected value}.
- Results go into a 2-entry output skid buffer, so a stalled consumer never loses a result and in_ready never depends combinationally on out_ready.

Parameters:
- WIDTH, 32, data and accumulator width in bits (legal range 1..128).
- INIT, 0, accumulator value after reset and after a clear with no accept.

Ports:
- clk  input  1  single clock; all state updates on posedge clk.
- rst  input  1  synchronous, active-high reset, sampled on posedge clk.
- in_valid  input  1  upstream sample valid.
- in_ready  output  1  stage can accept this cycle.
- in_data  input  WIDTH  sample to accumulate.
- in_bypass  input  1  selects in_data instead of the sum for out_bypass_data.
- sum_clear  input  1  restart the accumulation.
- out_valid  output  1  head result valid.
- out_ready  input  1  downstream accepts the head result.
- out_sum  output  WIDTH  accumulator value after this sample.
- out_bypass_data  output  WIDTH  in_bypass ? in_data : out_sum, captured at accept time.
- occupancy  output  2  entries held in the skid buffer (0..2).

Behaviour:
- Reset (rst=1 at a posedge), overriding everything else:
  - acc=INIT; buffer emptied.
  - occupancy=0, out_valid=0, out_sum=0, out_bypass_data=0, in_ready=1 (on the following cycle).
  - Reset mid-stream discards buffered results; no partial output survives.
- Handshakes:
  - accept = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - in_ready = (occupancy != 2). It is a function of registered state only.
- Accumulator update on accept:
  - new_acc = (sum_clear ? 0 : acc) + in_data, computed in WIDTH bits and wrapping modulo 2^WIDTH.
  - acc <= new_acc.
  - Pushed entry = {new_acc, in_bypass ? in_data : new_acc}.
- Accumulator with no accept:
  - sum_clear=1 sets acc <= INIT.
  - Otherwise acc holds.
- Buffer:
  - 2-entry FIFO. The head drives out_sum/out_bypass_data; out_valid = (occupancy != 0).
  - Latency is 1 cycle: a sample accepted at edge N appears at the head after edge N if the buffer was empty.
  - Push and pop in the same cycle: occupancy unchanged, order preserved. This is legal at occupancy 1.
  - At occupancy 2 no push is possible because in_ready=0. A pop that cycle takes occupancy to 1, and in_ready=1 the next cycle.
  - Pop at occupancy 0 cannot occur (out_valid=0).
- Holding values:
  - Head data is stable while out_valid=1 and out_ready=0.
  - With an empty buffer the outputs keep their last popped values; they are zero after reset.
- Inputs are ignored when in_valid=0, except sum_clear as above.
- Ordering: results leave in accept order; none are dropped or duplicated.

Optional Feature:
- Macro: ACCUM_SKID_SAT_EN.
- Defined: the add saturates. Operands are unsigned; if the carry out of bit WIDTH-1 is set, new_acc = all ones. The stage also outputs sat_flag (1 bit), which is set on any saturating accept and cleared by rst or sum_clear.
- Undefined: pure wrap-around add; port sat_flag is absent.

Decomposition:
- Package accum_skid_pkg:
  - typedef result_t, a packed struct {sum, bypass_data} sized by WIDTH via a package localparam default of 32.
  - localparam SKID_DEPTH=2.
- Sub-module skid_fifo2: a generic 2-entry valid/ready buffer carrying result_t, with ports clk, rst, push, push_data, pop, head_data, count.
- The top-level block holds the accumulator and the bypass mux, and instantiates skid_fifo2 once.

Test Plan:
- Reset then stream in_data=0,5,10,15 with out_ready=1 and no bypass -> out_sum 0,5,15,30 on consecutive cycles; out_bypass_data equals out_sum; occupancy stays at most 1.
- Assert in_bypass on the sample in_data=20 after running sum 30 -> out_sum=50, out_bypass_data=20.
- Hold out_ready=0 and offer 3 samples (1,2,3) -> 2 accepted, in_ready=0 with occupancy=2, head frozen at 1. Release out_ready -> results 1,3,6 in order, none lost.
- Set WIDTH=8 with acc=250 and in_data=10 -> out_sum=4 (wrap). With ACCUM_SKID_SAT_EN the same stimulus gives out_sum=255 and sat_flag=1.
- sum_clear together with in_data=7 after sum 100 -> out_sum=7. sum_clear alone, followed by in_data=3 -> out_sum=INIT+3.
- Assert rst with occupancy=2 mid-stream -> next cycle out_valid=0, occupancy=0, in_ready=1, out_sum=0; the next sample restarts from INIT.
